// File: rtl/full_adder.sv
// full_adder: DDS waveform generator. A 16-bit phase accumulator advances by
// ctrl each clock; its top 8 bits select registered sine, square, triangle
// and sawtooth samples (8-bit unsigned, offset binary).
module full_adder (
    input  logic       clk,
    input  logic       rstn,      // asynchronous, active-high despite the name
    input  logic [7:0] ctrl,
    output logic [7:0] wave_sin,
    output logic [7:0] wave_squ,
    output logic [7:0] wave_tri,
    output logic [7:0] wave_saw
);

    logic [15:0] acc;
    logic [7:0]  phase;
    logic [6:0]  q_idx;
    logic [6:0]  q_val;
    logic [7:0]  sin_next;
    logic [7:0]  squ_next;
    logic [7:0]  tri_next;

    assign phase = acc[15:8];

    // Quarter-wave sine ROM: the full 256-entry table is folded onto the
    // first quadrant (0..64). The second quadrant mirrors the index and the
    // lower half-period reflects the amplitude about midscale 128, which
    // reproduces round(128 + 127*sin(2*pi*k/256)) exactly for every k.
    always_comb begin
        q_idx = phase[6] ? 7'(7'd64 - {1'b0, phase[5:0]}) : {1'b0, phase[5:0]};
        q_val = '0;
        case (q_idx)
            7'd0:  q_val = 7'd0;   7'd1:  q_val = 7'd3;   7'd2:  q_val = 7'd6;   7'd3:  q_val = 7'd9;
            7'd4:  q_val = 7'd12;  7'd5:  q_val = 7'd16;  7'd6:  q_val = 7'd19;  7'd7:  q_val = 7'd22;
            7'd8:  q_val = 7'd25;  7'd9:  q_val = 7'd28;  7'd10: q_val = 7'd31;  7'd11: q_val = 7'd34;
            7'd12: q_val = 7'd37;  7'd13: q_val = 7'd40;  7'd14: q_val = 7'd43;  7'd15: q_val = 7'd46;
            7'd16: q_val = 7'd49;  7'd17: q_val = 7'd51;  7'd18: q_val = 7'd54;  7'd19: q_val = 7'd57;
            7'd20: q_val = 7'd60;  7'd21: q_val = 7'd63;  7'd22: q_val = 7'd65;  7'd23: q_val = 7'd68;
            7'd24: q_val = 7'd71;  7'd25: q_val = 7'd73;  7'd26: q_val = 7'd76;  7'd27: q_val = 7'd78;
            7'd28: q_val = 7'd81;  7'd29: q_val = 7'd83;  7'd30: q_val = 7'd85;  7'd31: q_val = 7'd88;
            7'd32: q_val = 7'd90;  7'd33: q_val = 7'd92;  7'd34: q_val = 7'd94;  7'd35: q_val = 7'd96;
            7'd36: q_val = 7'd98;  7'd37: q_val = 7'd100; 7'd38: q_val = 7'd102; 7'd39: q_val = 7'd104;
            7'd40: q_val = 7'd106; 7'd41: q_val = 7'd107; 7'd42: q_val = 7'd109; 7'd43: q_val = 7'd111;
            7'd44: q_val = 7'd112; 7'd45: q_val = 7'd113; 7'd46: q_val = 7'd115; 7'd47: q_val = 7'd116;
            7'd48: q_val = 7'd117; 7'd49: q_val = 7'd118; 7'd50: q_val = 7'd120; 7'd51: q_val = 7'd121;
            7'd52: q_val = 7'd122; 7'd53: q_val = 7'd122; 7'd54: q_val = 7'd123; 7'd55: q_val = 7'd124;
            7'd56: q_val = 7'd125; 7'd57: q_val = 7'd125; 7'd58: q_val = 7'd126; 7'd59: q_val = 7'd126;
            7'd60: q_val = 7'd126; 7'd61: q_val = 7'd127; 7'd62: q_val = 7'd127; 7'd63: q_val = 7'd127;
            7'd64: q_val = 7'd127;
            default: q_val = '0;
        endcase
        sin_next = phase[7] ? 8'(8'd128 - {1'b0, q_val}) : 8'(8'd128 + {1'b0, q_val});
    end

    // Square and triangle shapes derived directly from the phase bits.
    always_comb begin
        squ_next = phase[7] ? '0 : '1;
        tri_next = phase[7] ? ~{phase[6:0], 1'b0} : {phase[6:0], 1'b0};
    end

    // Accumulator advance and output registers; outputs use the pre-update phase.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            acc      <= '0;
            wave_sin <= '0;
            wave_squ <= '0;
            wave_tri <= '0;
            wave_saw <= '0;
        end else begin
            acc      <= acc + {8'd0, ctrl};
            wave_sin <= sin_next;
            wave_squ <= squ_next;
            wave_tri <= tri_next;
            wave_saw <= phase;
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: directed checks of the DDS generator against hand-computed
// waveform samples at known edge counts after reset release.
module tb_full_adder;

    logic       clk;
    logic       rstn;
    logic [7:0] ctrl;
    logic [7:0] wave_sin;
    logic [7:0] wave_squ;
    logic [7:0] wave_tri;
    logic [7:0] wave_saw;

    int unsigned n_vec;
    int unsigned n_err;
    int unsigned edge_cnt;

    full_adder dut (
        .clk      (clk),
        .rstn     (rstn),
        .ctrl     (ctrl),
        .wave_sin (wave_sin),
        .wave_squ (wave_squ),
        .wave_tri (wave_tri),
        .wave_saw (wave_saw)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] s, input logic [7:0] q,
                           input logic [7:0] t, input logic [7:0] w);
        chk({tag, ".sin"}, wave_sin, s);
        chk({tag, ".squ"}, wave_squ, q);
        chk({tag, ".tri"}, wave_tri, t);
        chk({tag, ".saw"}, wave_saw, w);
    endtask

    // Advance to the given post-release edge count, then sample on the falling edge.
    task automatic run_to(input int unsigned target);
        while (edge_cnt < target) begin
            @(posedge clk);
            edge_cnt++;
        end
        @(negedge clk);
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        edge_cnt = 0;
        rstn     = 1'b1;
        ctrl     = 8'd4;

        // Reset held with the clock running
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk_all("reset_hold", 8'd0, 8'd0, 8'd0, 8'd0);

        // Release and startup at ctrl=4
        rstn = 1'b0;
        run_to(1);
        chk_all("edge1", 8'd128, 8'd255, 8'd0, 8'd0);
        run_to(64);
        chk("edge64.saw", wave_saw, 8'd0);
        run_to(65);
        chk_all("edge65", 8'd131, 8'd255, 8'd2, 8'd1);
        run_to(2049);
        chk_all("p32", 8'd218, 8'd255, 8'd64, 8'd32);
        run_to(4097);
        chk_all("p64", 8'd255, 8'd255, 8'd128, 8'd64);
        run_to(8193);
        chk_all("p128", 8'd128, 8'd0, 8'd255, 8'd128);
        run_to(10241);
        chk_all("p160", 8'd38, 8'd0, 8'd191, 8'd160);
        run_to(12289);
        chk_all("p192", 8'd1, 8'd0, 8'd127, 8'd192);
        run_to(16384);
        chk_all("p255", 8'd125, 8'd0, 8'd1, 8'd255);
        run_to(16385);
        chk_all("wrap", 8'd128, 8'd255, 8'd0, 8'd0);

        // Frequency change to 255 with no reset; acc is 4 here
        ctrl = 8'd255;
        run_to(16386);
        chk("fchg_lat.saw", wave_saw, 8'd0);
        run_to(16387);
        chk("fchg1.saw", wave_saw, 8'd1);
        chk("fchg1.sin", wave_sin, 8'd131);
        run_to(16396);
        chk("fchg10.saw", wave_saw, 8'd9);

        // acc now 2809 (p=10); freeze it
        ctrl = 8'd0;
        run_to(16397);
        chk("hold_first.saw", wave_saw, 8'd10);
        run_to(16500);
        chk_all("hold", 8'd159, 8'd255, 8'd20, 8'd10);

        // Asynchronous reset mid-cycle, checked before any rising edge
        #2 rstn = 1'b1;
        #1;
        chk_all("async_rst", 8'd0, 8'd0, 8'd0, 8'd0);

        // Restart from reset: same sequence as power-up
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all("rst_hold2", 8'd0, 8'd0, 8'd0, 8'd0);
        ctrl     = 8'd4;
        rstn     = 1'b0;
        edge_cnt = 0;
        run_to(1);
        chk_all("restart1", 8'd128, 8'd255, 8'd0, 8'd0);
        run_to(64);
        chk("restart64.saw", wave_saw, 8'd0);
        run_to(65);
        chk("restart65.saw", wave_saw, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
